uart_dbus_master: RTL

UART_DBUS_MASTER -- requirements
Module: uart_dbus_master

---
 rtl/uart_dbus_master.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/uart_dbus_master.sv
`default_nettype none
// ============================================================================
// Module      : uart_dbus_master
// Description : Turns UART command frames into single dbus transfers and
//               sends the matching response bytes back over the UART.
//               Write frame : CMD_WR, addr[4 LE], data[4 LE] -> 0x06
//               Read frame  : CMD_RD, addr[4 LE]             -> r_data[4 LE]
//               No ack within ACK_TIMEOUT cycles             -> 0x15
// Revision    : 1.0 - initial release
// ============================================================================
module uart_dbus_master #(
    parameter int         ACK_TIMEOUT = 256,
    parameter logic [7:0] CMD_WR      = 8'h57,
    parameter logic [7:0] CMD_RD      = 8'h52
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_byte_i,
    input  logic        rx_valid_i,
    output logic [7:0]  tx_byte_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic        dbus_req_o,
    output logic        dbus_w_en_o,
    output logic [31:0] dbus_addr_o,
    output logic [31:0] dbus_w_data_o,
    input  logic        dbus_ack_i,
    input  logic [31:0] dbus_r_data_i,
    output logic        busy_o,
    output logic        drop_o
);

    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_ADDR = 3'd1;
    localparam logic [2:0] c_DATA = 3'd2;
    localparam logic [2:0] c_BUS  = 3'd3;
    localparam logic [2:0] c_RESP = 3'd4;

    // Wide enough to hold ACK_TIMEOUT itself, so any parameter value fits.
    localparam int              c_TW      = $clog2(ACK_TIMEOUT + 1);
    localparam logic [c_TW-1:0] c_TO_LAST = c_TW'(ACK_TIMEOUT - 1);

    localparam logic [7:0] c_ACK_BYTE = 8'h06;
    localparam logic [7:0] c_NAK_BYTE = 8'h15;

    logic [2:0]      r_state;
    logic [2:0]      w_state_nxt;
    logic            r_is_wr;
    logic            r_multi;
    logic            r_drop;
    logic [1:0]      r_cnt;
    logic [31:0]     r_addr;
    logic [31:0]     r_wdata;
    logic [31:0]     r_shift;
    logic [c_TW-1:0] r_tcnt;

    logic            w_rx_cmd;
    logic            w_last_byte;
    logic            w_tx_last;

    assign w_rx_cmd    = rx_valid_i && ((rx_byte_i == CMD_WR) || (rx_byte_i == CMD_RD));
    assign w_last_byte = rx_valid_i && (r_cnt == 2'd3);
    // Single-byte responses finish after one accept; reads after four.
    assign w_tx_last   = !r_multi || (r_cnt == 2'd3);

    // Request and write-enable only exist while the bus phase is active,
    // so addr/data/w_en are trivially stable for the whole request.
    assign dbus_req_o    = (r_state == c_BUS);
    assign dbus_w_en_o   = (r_state == c_BUS) && r_is_wr;
    assign dbus_addr_o   = r_addr;
    assign dbus_w_data_o = r_wdata;

    // The response shifter always holds the byte on offer in its low lane.
    assign tx_valid_o    = (r_state == c_RESP);
    assign tx_byte_o     = r_shift[7:0];
    assign busy_o        = (r_state != c_IDLE);
    assign drop_o        = r_drop;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; an ack in the expiry cycle still leaves via the
    // normal path because the datapath gives the ack priority.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: if (w_rx_cmd) w_state_nxt = c_ADDR;
            c_ADDR: if (w_last_byte) w_state_nxt = r_is_wr ? c_DATA : c_BUS;
            c_DATA: if (w_last_byte) w_state_nxt = c_BUS;
            c_BUS:  if (dbus_ack_i || (r_tcnt == c_TO_LAST)) w_state_nxt = c_RESP;
            c_RESP: if (tx_ready_i && w_tx_last) w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // Frame assembly, bus timeout, response loading/shifting and drop flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_is_wr <= 1'b0;
            r_multi <= 1'b0;
            r_drop  <= 1'b0;
            r_cnt   <= 2'd0;
            r_addr  <= 32'h0;
            r_wdata <= 32'h0;
            r_shift <= 32'h0;
            r_tcnt  <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_rx_cmd) begin
                        r_is_wr <= (rx_byte_i == CMD_WR);
                        r_cnt   <= 2'd0;
                    end
                end
                c_ADDR: begin
                    if (rx_valid_i) begin
                        r_addr[{r_cnt, 3'b000} +: 8] <= rx_byte_i;
                        r_cnt                        <= r_cnt + 2'd1;
                    end
                end
                c_DATA: begin
                    if (rx_valid_i) begin
                        r_wdata[{r_cnt, 3'b000} +: 8] <= rx_byte_i;
                        r_cnt                         <= r_cnt + 2'd1;
                    end
                end
                c_BUS: begin
                    if (rx_valid_i) begin
                        r_drop <= 1'b1;
                    end
                    if (dbus_ack_i) begin
                        r_tcnt <= '0;
                        r_cnt  <= 2'd0;
                        if (r_is_wr) begin
                            r_shift <= {24'h0, c_ACK_BYTE};
                            r_multi <= 1'b0;
                        end else begin
                            r_shift <= dbus_r_data_i;
                            r_multi <= 1'b1;
                        end
                    end else if (r_tcnt == c_TO_LAST) begin
                        r_tcnt  <= '0;
                        r_cnt   <= 2'd0;
                        r_shift <= {24'h0, c_NAK_BYTE};
                        r_multi <= 1'b0;
                    end else begin
                        r_tcnt <= r_tcnt + c_TW'(1);
                    end
                end
                c_RESP: begin
                    if (rx_valid_i) begin
                        r_drop <= 1'b1;
                    end
                    if (tx_ready_i) begin
                        r_shift <= {8'h00, r_shift[31:8]};
                        r_cnt   <= r_cnt + 2'd1;
                    end
                end
                default: begin
                    r_cnt  <= 2'd0;
                    r_tcnt <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
